ysyx_23060203_irq_ctrl: RTL

Machine-mode interrupt controller and trap sequencer beside the write-back unit. It owns a 64-bit machine timer (`mtime`/`mtimecmp`) and samples an external interrupt line. It holds instruction fetch, waits for the pipeline to drain, then issues a single-cycle trap request that the CSR file and the control-flow redirect path consume. Instruction-caused redirects from write-back always take priority over interrupt entry.

---
 rtl/ysyx_23060203_irq_ctrl_if.sv | 36 +++
 rtl/ysyx_23060203_irq_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_irq_ctrl_if.sv
// rtl/ysyx_23060203_irq_ctrl_if.sv - write-back commit and trap-request bundle between pipeline and irq controller
interface ysyx_23060203_irq_ctrl_if;
    logic        commit_valid;
    logic [31:0] commit_dnpc;
    logic        commit_flush;
    logic        pipe_idle;
    logic        fetch_hold;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_dnpc;

    modport master (
        input  commit_valid,
        input  commit_dnpc,
        input  commit_flush,
        input  pipe_idle,
        output fetch_hold,
        output trap_valid,
        output trap_cause,
        output trap_epc,
        output trap_dnpc
    );

    modport slave (
        output commit_valid,
        output commit_dnpc,
        output commit_flush,
        output pipe_idle,
        input  fetch_hold,
        input  trap_valid,
        input  trap_cause,
        input  trap_epc,
        input  trap_dnpc
    );
endinterface

// File: rtl/ysyx_23060203_irq_ctrl.sv
// rtl/ysyx_23060203_irq_ctrl.sv - machine timer, interrupt pending logic and trap-entry sequencer
// The machine timer is only built when YSYX_23060203_IRQ_TIMER_EN is defined.
module ysyx_23060203_irq_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h3000_0000,
    parameter int unsigned TIMER_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ext_irq,
    input  logic        mstatus_mie,
    input  logic        mie_mtie,
    input  logic        mie_meie,
    input  logic [31:0] mtvec,
    input  logic        cmp_wen,
    input  logic        cmp_hi,
    input  logic [31:0] cmp_wdata,
    output logic [31:0] mtime_lo,
    output logic [31:0] mtime_hi,
    output logic        mip_mtip,
    output logic        mip_meip,
    ysyx_23060203_irq_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        TAKE   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] epc;
    logic        take_req;
    logic        ext_take;
    logic        unused_inputs;

`ifdef YSYX_23060203_IRQ_TIMER_EN
    localparam logic [15:0] DIV_LAST = 16'(TIMER_DIV - 1);

    logic [15:0] prescaler;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler <= '0;
            mtime     <= '0;
            mtimecmp  <= '1;
        end else begin
            if (prescaler == DIV_LAST) begin
                prescaler <= '0;
                mtime     <= mtime + 64'd1;
            end else begin
                prescaler <= prescaler + 16'd1;
            end
            if (cmp_wen) begin
                if (cmp_hi) begin
                    mtimecmp[63:32] <= cmp_wdata;
                end else begin
                    mtimecmp[31:0]  <= cmp_wdata;
                end
            end
        end
    end

    assign mtime_lo      = mtime[31:0];
    assign mtime_hi      = mtime[63:32];
    assign mip_mtip      = (mtime >= mtimecmp);
    assign unused_inputs = ^mtvec[1:0];
`else
    assign mtime_lo      = '0;
    assign mtime_hi      = '0;
    assign mip_mtip      = 1'b0;
    assign unused_inputs = ^{cmp_wen, cmp_hi, cmp_wdata, mtvec[1:0], TIMER_DIV};
`endif

    assign mip_meip = ext_irq;
    assign ext_take = mip_meip & mie_meie;
    assign take_req = mstatus_mie & (ext_take | (mip_mtip & mie_mtie));

    // Flushing commits still retire, so they also update the resume PC.
    always_ff @(posedge clock) begin
        if (reset) begin
            epc <= RESET_PC;
        end else if (bus.commit_valid) begin
            epc <= bus.commit_dnpc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            bus.fetch_hold <= 1'b0;
            bus.trap_valid <= 1'b0;
            bus.trap_cause <= '0;
            bus.trap_epc   <= '0;
            bus.trap_dnpc  <= '0;
        end else begin
            bus.trap_valid <= 1'b0;
            bus.trap_cause <= '0;
            bus.trap_epc   <= '0;
            bus.trap_dnpc  <= '0;
            case (state)
                IDLE: begin
                    if (take_req) begin
                        state          <= HOLD;
                        bus.fetch_hold <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!take_req) begin
                        state          <= IDLE;
                        bus.fetch_hold <= 1'b0;
                    end else if (bus.pipe_idle && !bus.commit_flush && !bus.commit_valid) begin
                        state          <= TAKE;
                        bus.fetch_hold <= 1'b1;
                        bus.trap_valid <= 1'b1;
                        bus.trap_cause <= ext_take ? 32'h8000_000B : 32'h8000_0007;
                        bus.trap_epc   <= epc;
                        bus.trap_dnpc  <= {mtvec[31:2], 2'b00};
                    end
                end
                TAKE: begin
                    state          <= SETTLE;
                    bus.fetch_hold <= 1'b1;
                end
                // One dead cycle lets the CSR file clear mstatus.MIE before re-arming.
                SETTLE: begin
                    state          <= IDLE;
                    bus.fetch_hold <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    bus.fetch_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule
